// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB / 2-bit direction predictor.
// Entry tag field is sized for the widest supported tag; upper bits stay zero.
package bp_pkg;

    localparam int BP_XLEN    = 32;
    localparam int BP_TAG_MAX = 32;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_MAX-1:0] tag;
        logic [BP_XLEN-1:0]    target;
        logic [1:0]            ctr;
    } bp_entry_t;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, mispredict detection
// and saturating branch / mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [XLEN-1:0]  i_pc,
    output logic             o_pred_taken,
    output logic [XLEN-1:0]  o_pred_target,
    input  logic             i_upd_vld,
    input  logic [XLEN-1:0]  i_upd_pc,
    input  logic             i_upd_taken,
    input  logic [XLEN-1:0]  i_upd_target,
    input  logic             i_upd_pred_taken,
    input  logic [XLEN-1:0]  i_upd_pred_target,
    output logic             o_mispredict,
    output logic [XLEN-1:0]  o_redirect_pc,
    input  logic             i_stat_clr,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mp_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_entry_t tbl_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    bp_entry_t        rd_e;
    logic             rd_hit;

    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    bp_entry_t        old_e;
    bp_entry_t        wr_e;
    logic             wr_hit;
    logic             wr_en;

    assign rd_idx = i_pc[IDX_W+1:2];
    assign rd_tag = i_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign rd_e   = tbl_q[rd_idx];
    assign rd_hit = rd_e.valid && (rd_e.tag == BP_TAG_MAX'(rd_tag));

    assign o_pred_taken  = rd_hit && rd_e.ctr[1];
    assign o_pred_target = o_pred_taken ? XLEN'(rd_e.target)
                                        : i_pc + XLEN'(4);

    assign o_mispredict = i_upd_vld &&
        ((i_upd_taken != i_upd_pred_taken) ||
         (i_upd_taken && (i_upd_target != i_upd_pred_target)));
    assign o_redirect_pc = (i_upd_vld && i_upd_taken) ? i_upd_target
                                                      : i_upd_pc + XLEN'(4);

    assign wr_idx = i_upd_pc[IDX_W+1:2];
    assign wr_tag = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign old_e  = tbl_q[wr_idx];
    assign wr_hit = old_e.valid && (old_e.tag == BP_TAG_MAX'(wr_tag));

    // A not-taken miss never allocates, so cold fall-through code stays out.
    always_comb begin
        wr_en = i_upd_vld && (wr_hit || i_upd_taken);
        wr_e  = old_e;
        if (wr_hit) begin
            wr_e.ctr = ctr_next(old_e.ctr, i_upd_taken);
            if (i_upd_taken) wr_e.target = BP_XLEN'(i_upd_target);
        end else begin
            wr_e.valid  = 1'b1;
            wr_e.tag    = BP_TAG_MAX'(wr_tag);
            wr_e.target = BP_XLEN'(i_upd_target);
            wr_e.ctr    = CTR_WT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (wr_en) begin
            tbl_q[wr_idx] <= wr_e;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk_i  (i_clk),
        .rst_ni (i_rst),
        .clr_i  (i_stat_clr),
        .inc_i  (i_upd_vld),
        .cnt_o  (o_br_count)
    );

    sat_counter #(.W(CNT_W)) u_mp_cnt (
        .clk_i  (i_clk),
        .rst_ni (i_rst),
        .clr_i  (i_stat_clr),
        .inc_i  (o_mispredict),
        .cnt_o  (o_mp_count)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; narrow stat counters make saturation
// reachable in a short run.
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int TAG_W   = 10;
    localparam int CNT_W   = 4;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [XLEN-1:0]  i_pc;
    logic             o_pred_taken;
    logic [XLEN-1:0]  o_pred_target;
    logic             i_upd_vld;
    logic [XLEN-1:0]  i_upd_pc;
    logic             i_upd_taken;
    logic [XLEN-1:0]  i_upd_target;
    logic             i_upd_pred_taken;
    logic [XLEN-1:0]  i_upd_pred_target;
    logic             o_mispredict;
    logic [XLEN-1:0]  o_redirect_pc;
    logic             i_stat_clr;
    logic [CNT_W-1:0] o_br_count;
    logic [CNT_W-1:0] o_mp_count;

    int errs   = 0;
    int checks = 0;

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_pc              (i_pc),
        .o_pred_taken      (o_pred_taken),
        .o_pred_target     (o_pred_target),
        .i_upd_vld         (i_upd_vld),
        .i_upd_pc          (i_upd_pc),
        .i_upd_taken       (i_upd_taken),
        .i_upd_target      (i_upd_target),
        .i_upd_pred_taken  (i_upd_pred_taken),
        .i_upd_pred_target (i_upd_pred_target),
        .o_mispredict      (o_mispredict),
        .o_redirect_pc     (o_redirect_pc),
        .i_stat_clr        (i_stat_clr),
        .o_br_count        (o_br_count),
        .o_mp_count        (o_mp_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt);
        i_upd_vld         = 1'b1;
        i_upd_pc          = pc;
        i_upd_taken       = tk;
        i_upd_target      = tgt;
        i_upd_pred_taken  = ptk;
        i_upd_pred_target = ptgt;
        #1;
    endtask

    task automatic idle();
        i_upd_vld = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt);
        i_pc = pc;
        #1;
        check({tag, ".taken"}, 32'(o_pred_taken), 32'(tk));
        check({tag, ".target"}, o_pred_target, tgt);
    endtask

    task automatic cnts(input string tag, input int br, input int mp);
        check({tag, ".br"}, 32'(o_br_count), br);
        check({tag, ".mp"}, 32'(o_mp_count), mp);
    endtask

    initial begin
        i_rst             = 1'b0;
        i_pc              = 32'h100;
        i_upd_vld         = 1'b0;
        i_upd_pc          = '0;
        i_upd_taken       = 1'b0;
        i_upd_target      = '0;
        i_upd_pred_taken  = 1'b0;
        i_upd_pred_target = '0;
        i_stat_clr        = 1'b0;
        #2;
        look("in_rst", 32'h100, 1'b0, 32'h104);
        cnts("in_rst", 0, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        tick();

        look("post_rst", 32'h100, 1'b0, 32'h104);
        cnts("post_rst", 0, 0);

        // cold taken branch; same-cycle lookup sees the old (empty) entry
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        check("cold.mp", 32'(o_mispredict), 1);
        check("cold.redir", o_redirect_pc, 32'h200);
        look("cold.same", 32'h100, 1'b0, 32'h104);
        tick();
        idle();
        look("cold.next", 32'h100, 1'b1, 32'h200);
        cnts("cold", 1, 1);

        // 10 -> 01
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        check("nt.mp", 32'(o_mispredict), 1);
        check("nt.redir", o_redirect_pc, 32'h104);
        tick();
        idle();
        look("wnt", 32'h100, 1'b0, 32'h104);
        cnts("wnt", 2, 2);

        // 01 -> 10 -> 11 -> 11
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        check("walk1.mp", 32'(o_mispredict), 1);
        tick();
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        check("walk2.mp", 32'(o_mispredict), 0);
        tick();
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        tick();
        // 11 -> 10 still predicts taken
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        tick();
        idle();
        look("st_nt", 32'h100, 1'b1, 32'h200);
        cnts("walk", 6, 4);

        // alias at same index, different tag
        look("alias.miss", 32'h200, 1'b0, 32'h204);
        upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        check("alias.mp", 32'(o_mispredict), 1);
        look("alias.same", 32'h200, 1'b0, 32'h204);
        tick();
        idle();
        look("alias.hit", 32'h200, 1'b1, 32'h300);
        look("alias.old", 32'h100, 1'b0, 32'h104);
        cnts("alias", 7, 5);

        // correctly predicted taken
        upd(32'h200, 1'b1, 32'h300, 1'b1, 32'h300);
        check("ok.mp", 32'(o_mispredict), 0);
        check("ok.redir", o_redirect_pc, 32'h300);
        tick();
        idle();
        cnts("ok", 8, 5);

        // direction right, target wrong
        upd(32'h200, 1'b1, 32'h340, 1'b1, 32'h300);
        check("tgt.mp", 32'(o_mispredict), 1);
        look("tgt.same", 32'h200, 1'b1, 32'h300);
        tick();
        idle();
        look("tgt.next", 32'h200, 1'b1, 32'h340);
        cnts("tgt", 9, 6);

        // no update valid: redirect is pc+4, no flush
        i_upd_pc          = 32'h200;
        i_upd_taken       = 1'b1;
        i_upd_pred_taken  = 1'b0;
        #1;
        check("novld.mp", 32'(o_mispredict), 0);
        check("novld.redir", o_redirect_pc, 32'h204);

        // not-taken miss leaves the table alone
        upd(32'h404, 1'b0, 32'h0, 1'b0, 32'h408);
        check("ntmiss.mp", 32'(o_mispredict), 0);
        tick();
        idle();
        look("ntmiss", 32'h404, 1'b0, 32'h408);
        cnts("ntmiss", 10, 6);

        // clear wins over a same-cycle mispredicting update
        i_stat_clr = 1'b1;
        upd(32'h800, 1'b0, 32'h0, 1'b1, 32'h900);
        tick();
        i_stat_clr = 1'b0;
        idle();
        cnts("clr", 0, 0);

        upd(32'h800, 1'b0, 32'h0, 1'b1, 32'h900);
        repeat (20) tick();
        idle();
        cnts("sat", 15, 15);
        upd(32'h800, 1'b0, 32'h0, 1'b1, 32'h900);
        tick();
        idle();
        cnts("sat2", 15, 15);

        for (int i = 0; i < 5; i++) begin
            upd(32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(16 * i),
                1'b0, 32'h0);
            tick();
        end
        idle();
        look("alloc", 32'h1008, 1'b1, 32'h2020);

        // reset lands mid-update, between edges
        upd(32'h1000, 1'b1, 32'h3000, 1'b1, 32'h2000);
        #1;
        i_rst = 1'b0;
        #1;
        look("mid_rst", 32'h1000, 1'b0, 32'h1004);
        cnts("mid_rst", 0, 0);
        check("mid_rst.mp", 32'(o_mispredict), 1);
        check("mid_rst.redir", o_redirect_pc, 32'h3000);
        idle();
        @(negedge i_clk);
        i_rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            look("rst_miss", 32'h1000 + 32'(4 * i), 1'b0,
                 32'h1004 + 32'(4 * i));
        end
        cnts("rst_end", 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
